// File: rtl/sample_serializer_pkg.sv
// Shared tone-generator constants and the MSB-first bit picker
// used by the serializer datapath.
package sample_serializer_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 32;
  localparam int HALF_BITS  = FRAME_BITS / 2;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int POS_W      = $clog2(SAMPLE_W);

  // Bit of the sample sent at a given slot within one channel (slot 0 = MSB).
  function automatic logic serial_bit(input logic [SAMPLE_W-1:0] sample,
                                      input logic [POS_W-1:0] chan_bit);
    logic [POS_W-1:0] pos;
    pos = POS_W'(SAMPLE_W - 1) - chan_bit;
    return sample[pos];
  endfunction

endpackage

// File: rtl/sample_serializer_clock_gen.sv
// Bit-clock timebase: divides clk_in into BCLK and a 32-bit LR frame,
// with registered bclk/lrck and decoded bit/frame start strobes.
module serial_clock_gen
  import sample_serializer_pkg::*;
#(
  parameter int BCLK_DIV = 32
) (
  input  logic             clk_in,
  input  logic             reset_in,
  output logic             bclk,
  output logic             lrck,
  output logic [POS_W-1:0] chan_bit,
  output logic             bit_start,
  output logic             frame_start
);

  localparam int DIV_W = $clog2(BCLK_DIV);

  logic [DIV_W-1:0] div_cnt_r;
  logic [BIT_W-1:0] bit_cnt_r;
  logic             bclk_r;
  logic             lrck_r;

  // Divider and bit counters; bclk/lrck are registered decodes of them.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      div_cnt_r <= {DIV_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      bclk_r    <= 1'b0;
      lrck_r    <= 1'b0;
    end else begin
      if (div_cnt_r == DIV_W'(BCLK_DIV - 1)) begin
        div_cnt_r <= {DIV_W{1'b0}};
        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
        bit_cnt_r <= bit_cnt_r;
      end
      bclk_r <= (div_cnt_r >= DIV_W'(BCLK_DIV / 2));
      lrck_r <= (bit_cnt_r >= BIT_W'(HALF_BITS));
    end
  end

  assign bclk        = bclk_r;
  assign lrck        = lrck_r;
  assign chan_bit    = bit_cnt_r[POS_W-1:0];
  assign bit_start   = (div_cnt_r == {DIV_W{1'b0}});
  assign frame_start = bit_start && (bit_cnt_r == {BIT_W{1'b0}});

endmodule

// File: rtl/sample_serializer.sv
// Mono I2S-style serializer: one-entry holding buffer feeding a 32-bit
// left-justified frame, with underrun/overrun pulses.
module sample_serializer
  import sample_serializer_pkg::*;
#(
  parameter int BCLK_DIV = 32
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic [SAMPLE_W-1:0] data_in,
  input  logic                data_valid_in,
  output logic                bclk_out,
  output logic                lrck_out,
  output logic                sdata_out,
  output logic                underrun_out,
  output logic                overrun_out
);

  logic             bclk_s;
  logic             lrck_s;
  logic [POS_W-1:0] chan_bit_s;
  logic             bit_start_s;
  logic             frame_start_s;

  serial_clock_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clock_gen (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .bclk        (bclk_s),
    .lrck        (lrck_s),
    .chan_bit    (chan_bit_s),
    .bit_start   (bit_start_s),
    .frame_start (frame_start_s)
  );

  logic [SAMPLE_W-1:0] holding_r, holding_next_s;
  logic [SAMPLE_W-1:0] frame_r, frame_next_s;
  logic                full_r, full_next_s;
  logic                primed_r, primed_next_s;
  logic                underrun_r, underrun_next_s;
  logic                overrun_r, overrun_next_s;
  logic                sdata_r;

  // Buffer policy: a valid coinciding with a frame load bypasses the holding register.
  always_comb begin
    holding_next_s  = holding_r;
    frame_next_s    = frame_r;
    full_next_s     = full_r;
    primed_next_s   = primed_r;
    underrun_next_s = 1'b0;
    overrun_next_s  = 1'b0;
    if (frame_start_s) begin
      if (data_valid_in) begin
        frame_next_s  = data_in;
        full_next_s   = 1'b0;
        primed_next_s = 1'b1;
      end else if (full_r) begin
        frame_next_s = holding_r;
        full_next_s  = 1'b0;
      end else begin
        underrun_next_s = primed_r;
      end
    end else if (data_valid_in) begin
      holding_next_s = data_in;
      full_next_s    = 1'b1;
      primed_next_s  = 1'b1;
      overrun_next_s = full_r;
    end else begin
      holding_next_s = holding_r;
    end
  end

  // Datapath state; sdata picks its bit from the frame as it will be after this edge.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      holding_r  <= {SAMPLE_W{1'b0}};
      frame_r    <= {SAMPLE_W{1'b0}};
      full_r     <= 1'b0;
      primed_r   <= 1'b0;
      underrun_r <= 1'b0;
      overrun_r  <= 1'b0;
      sdata_r    <= 1'b0;
    end else begin
      holding_r  <= holding_next_s;
      frame_r    <= frame_next_s;
      full_r     <= full_next_s;
      primed_r   <= primed_next_s;
      underrun_r <= underrun_next_s;
      overrun_r  <= overrun_next_s;
      if (bit_start_s) begin
        sdata_r <= serial_bit(frame_next_s, chan_bit_s);
      end else begin
        sdata_r <= sdata_r;
      end
    end
  end

  assign bclk_out     = bclk_s;
  assign lrck_out     = lrck_s;
  assign sdata_out    = sdata_r;
  assign underrun_out = underrun_r;
  assign overrun_out  = overrun_r;

endmodule

// File: tb/tb_sample_serializer.sv
// Directed + random bench for sample_serializer at BCLK_DIV = 4 (128-cycle frames),
// checked against a cycle-index reference model and captured serial words.
module tb_sample_serializer;

  localparam int DIV   = 4;
  localparam int FRAME = DIV * 32;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic [15:0] data_in = 16'h0000;
  logic        data_valid_in = 1'b0;
  logic        bclk_out, lrck_out, sdata_out, underrun_out, overrun_out;

  sample_serializer #(.BCLK_DIV(DIV)) dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .data_in       (data_in),
    .data_valid_in (data_valid_in),
    .bclk_out      (bclk_out),
    .lrck_out      (lrck_out),
    .sdata_out     (sdata_out),
    .underrun_out  (underrun_out),
    .overrun_out   (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model: k counts cycles since reset release (k = 0 is the first load cycle).
  int          k;
  logic [15:0] m_hold, m_frame;
  logic        m_full, m_primed;
  logic        e_bclk, e_lrck, e_sdata, e_under, e_over;

  // Observation statistics over a window.
  logic        prev_bclk;
  logic [15:0] sh, cap_l, cap_r;
  int          nbits, n_under, n_over, lr_low, lr_high;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    k = 0; m_hold = 16'h0000; m_frame = 16'h0000; m_full = 1'b0; m_primed = 1'b0;
    e_bclk = 1'b0; e_lrck = 1'b0; e_sdata = 1'b0; e_under = 1'b0; e_over = 1'b0;
    prev_bclk = 1'b0; sh = 16'h0000; nbits = 0;
  endtask

  // Called at a negedge: leaves the bench at the negedge of the k = 0 cycle.
  task automatic do_reset(input int n);
    reset_in = 1'b1;
    data_valid_in = 1'b0;
    repeat (n) @(negedge clk_in);
    check("reset_outputs", {11'd0, bclk_out, lrck_out, sdata_out, underrun_out, overrun_out}, 16'h0000);
    reset_in = 1'b0;
    model_init();
  endtask

  // Check this cycle's outputs, drive inputs, advance the model one cycle.
  task automatic cycle(input logic v, input logic [15:0] d);
    int dv, bt;
    logic load;
    check("bclk", bclk_out, e_bclk);
    check("lrck", lrck_out, e_lrck);
    check("sdata", sdata_out, e_sdata);
    check("underrun", underrun_out, e_under);
    check("overrun", overrun_out, e_over);
    if (lrck_out) lr_high++; else lr_low++;
    n_under += int'(underrun_out);
    n_over  += int'(overrun_out);
    if (!prev_bclk && bclk_out) begin
      sh = {sh[14:0], sdata_out};
      nbits++;
      if (nbits == 16) begin
        if (lrck_out) cap_r = sh; else cap_l = sh;
        check("word_vs_model", sh, m_frame);
        nbits = 0;
      end
    end
    prev_bclk = bclk_out;

    data_valid_in = v;
    data_in = d;

    dv = k % DIV;
    bt = (k / DIV) % 32;
    load = (dv == 0) && (bt == 0);
    e_under = 1'b0;
    e_over = 1'b0;
    if (load) begin
      if (v) begin
        m_frame = d; m_full = 1'b0; m_primed = 1'b1;
      end else if (m_full) begin
        m_frame = m_hold; m_full = 1'b0;
      end else begin
        e_under = m_primed;
      end
    end else if (v) begin
      e_over = m_full; m_hold = d; m_full = 1'b1; m_primed = 1'b1;
    end
    e_bclk = (dv >= DIV / 2);
    e_lrck = (bt >= 16);
    if (dv == 0) e_sdata = m_frame[15 - (bt % 16)];
    k++;
    @(negedge clk_in);
  endtask

  task automatic to_frame_start();
    while (k % FRAME != 1) cycle(1'b0, 16'h0000);
  endtask

  task automatic to_load();
    while (k % FRAME != 0) cycle(1'b0, 16'h0000);
  endtask

  // One frame's worth of observation, starting the cycle after a frame load.
  task automatic window(input logic v, input logic [15:0] d);
    n_under = 0; n_over = 0; lr_low = 0; lr_high = 0;
    cap_l = 16'hxxxx; cap_r = 16'hxxxx;
    cycle(v, d);
    repeat (FRAME - 1) cycle(1'b0, 16'h0000);
  endtask

  initial begin
    model_init();
    @(negedge clk_in);
    do_reset(3);

    // 0xA5C3 goes out in the next frame on both channels.
    cycle(1'b0, 16'h0000);
    cycle(1'b1, 16'hA5C3);
    to_frame_start();
    window(1'b0, 16'h0000);
    check("a5c3_left", cap_l, 16'hA5C3);
    check("a5c3_right", cap_r, 16'hA5C3);
    check("lrck_low_cycles", 16'(lr_low), 16'd64);
    check("lrck_high_cycles", 16'(lr_high), 16'd64);
    check("a5c3_no_underrun", 16'(n_under), 16'd0);

    // No new sample: frame repeats, one underrun pulse.
    window(1'b0, 16'h0000);
    check("repeat_left", cap_l, 16'hA5C3);
    check("underrun_once", 16'(n_under), 16'd1);

    // Two samples in one frame: one overrun, newer wins.
    n_over = 0;
    cycle(1'b1, 16'h1111);
    cycle(1'b0, 16'h0000);
    cycle(1'b1, 16'h2222);
    cycle(1'b0, 16'h0000);
    cycle(1'b0, 16'h0000);
    check("overrun_once", 16'(n_over), 16'd1);
    to_frame_start();
    window(1'b0, 16'h0000);
    check("overrun_newer_left", cap_l, 16'h2222);
    check("overrun_newer_right", cap_r, 16'h2222);
    check("overrun_no_underrun", 16'(n_under), 16'd0);

    // Valid in the load cycle goes straight out with no flag pulses.
    to_load();
    cycle(1'b1, 16'h8001);
    window(1'b0, 16'h0000);
    check("bypass_left", cap_l, 16'h8001);
    check("bypass_no_underrun", 16'(n_under), 16'd0);
    check("bypass_no_overrun", 16'(n_over), 16'd0);

    // Reset in the middle of the right channel.
    while (k % FRAME != 20 * DIV + 2) cycle(1'b0, 16'h0000);
    do_reset(3);
    cycle(1'b0, 16'h0000);
    window(1'b0, 16'h0000);
    check("post_reset_no_underrun", 16'(n_under), 16'd0);
    check("post_reset_left", cap_l, 16'h0000);
    check("post_reset_lrck_low", 16'(lr_low), 16'd64);

    // Full-scale extremes.
    cycle(1'b1, 16'h7FFF);
    to_frame_start();
    window(1'b1, 16'h8000);
    check("maxpos_left", cap_l, 16'h7FFF);
    check("maxpos_right", cap_r, 16'h7FFF);
    window(1'b0, 16'h0000);
    check("maxneg_left", cap_l, 16'h8000);

    // Random traffic against the model.
    repeat (4000) cycle(($urandom_range(0, 199) < 2), 16'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_serializer.md
SAMPLE_SERIALIZER -- requirements
Module: sample_serializer

Interface
REQ-001 SHALL provide parameter BCLK_DIV, default 32, clk_in cycles per BCLK period; even, >=4. The default makes one frame 1024 cycles, matching one mixer sample period.
REQ-002 SHALL have port clk_in, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_in, input, 1, synchronous active-high reset.
REQ-004 SHALL have port data_in, input, 16, signed two's-complement mixed sample.
REQ-005 SHALL have port data_valid_in, input, 1, one-cycle strobe qualifying data_in.
REQ-006 SHALL have port bclk_out, output, 1, serial bit clock.
REQ-007 SHALL have port lrck_out, output, 1, channel select: 0 = left, 1 = right.
REQ-008 SHALL have port sdata_out, output, 1, serial data, MSB first, left-justified.
REQ-009 SHALL have port underrun_out, output, 1, one-cycle pulse: frame reused the old sample.
REQ-010 SHALL have port overrun_out, output, 1, one-cycle pulse: an unconsumed sample was overwritten.

Function
REQ-011 SHALL keep div_cnt, wrapping 0..BCLK_DIV-1 every cycle, and bit_cnt, wrapping 0..31, which increments when div_cnt wraps.
REQ-012 SHALL drive bclk_out = 0 while div_cnt < BCLK_DIV/2, else 1, so data changes on the falling edge and is sampled on the rising edge.
REQ-013 SHALL drive lrck_out = 0 while bit_cnt is 0..15 and 1 while bit_cnt is 16..31.
REQ-014 SHALL drive sdata_out = frame_sample[15 - (bit_cnt mod 16)], changing only in cycles with div_cnt == 0; both channels carry the same mono sample.
REQ-015 SHALL keep a one-entry holding register and a full flag; data_valid_in writes data_in into it and sets full.
REQ-016 SHALL perform a frame load when div_cnt == 0 and bit_cnt == 0, copying holding into frame_sample and clearing full.
REQ-017 SHALL, when data_valid_in coincides with a frame load, load data_in directly into frame_sample, leave full cleared, and pulse neither flag.
REQ-018 SHALL, at a frame load with full == 0 and no coincident valid, keep frame_sample unchanged and pulse underrun_out, but only if the primed flag is set.
REQ-019 SHALL set the primed flag on the first accepted sample after reset.
REQ-020 SHALL pulse overrun_out in the cycle after a data_valid_in that arrives while full == 1 outside a frame load; the newer sample replaces the held one.
REQ-021 SHALL update flags, counters and outputs as registered state, with flag pulses asserted in the cycle after the causing event.
REQ-022 SHALL have a latency of at most 1024 + 1 cycles at the default BCLK_DIV from accepted data_valid_in to the first sdata_out bit of that sample.

Reset
REQ-023 SHALL, while reset_in is high, clear div_cnt, bit_cnt, holding, full, primed and frame_sample to 0.
REQ-024 SHALL hold bclk_out, lrck_out, sdata_out, underrun_out and overrun_out at 0 during reset and in the first cycle after release.
REQ-025 SHALL, on reset mid-frame, abandon the frame with no partial-frame completion, and start a fresh frame with a frame load at div_cnt == 0, bit_cnt == 0 after release.

Structure
REQ-026 SHALL take SAMPLE_W = 16 and FRAME_BITS = 32 from the shared tone-generator package, shared with the mixer.
REQ-027 SHALL place div_cnt/bit_cnt generation in one sub-module, serial_clock_gen, that outputs bclk, lrck, bit index and a frame_start strobe.
REQ-028 SHALL contain no other sub-modules.

Verification (BCLK_DIV = 4, so a frame is 128 cycles)
REQ-029 SHALL cover: reset, then valid with 0xA5C3 -> next frame carries sdata bits 1010010111000011 in left and repeated in right, with lrck low for 64 cycles then high for 64.
REQ-030 SHALL cover: primed, then no valid for one frame -> frame repeats the prior sample and underrun_out is high exactly one cycle, one cycle after the frame load.
REQ-031 SHALL cover: valid 0x1111 then valid 0x2222 within one frame -> overrun_out pulses once and the next frame transmits 0x2222.
REQ-032 SHALL cover: valid 0x8001 in the frame-load cycle -> that same frame transmits 0x8001, with no underrun or overrun pulse.
REQ-033 SHALL cover: reset asserted at bit_cnt 20 -> all outputs 0, the frame restarts after release, and no underrun occurs at the first load.
REQ-034 SHALL cover: samples 0x7FFF then 0x8000 -> left sdata is 0 then fifteen 1s, then 1 then fifteen 0s.
